// File: rtl/scroll_message_buffer.sv
// scroll_message_buffer
//   Loadable, pausable, bidirectional message scroller feeding the HEX5..HEX0
//   ticker. Stores up to DEPTH 5-bit character codes and slides a 6-digit
//   window over a frame made of the message followed by six blanks.
//
// Ports
//   clk, resetn        clock, asynchronous active-low reset
//   tick               1-cycle scroll enable pulse
//   clr                synchronous clear of message and state
//   wr_en, wr_char     append one character code (0x00-0x0F glyph, 0x10-0x1F blank)
//   start              begin/restart scrolling at window position 0
//   pause              level; freezes scrolling while high
//   dir                0 = scroll left (pos+1), 1 = scroll right (pos-1)
//   HEX5..HEX0         active-low 7-segment patterns, bit0 = segment a
//   len, pos           stored character count, window start index
//   full, busy, wrap   len == DEPTH, scrolling (RUN/HOLD), 1-cycle wrap pulse
//
// Build option
//   SCROLL_ONESHOT_EN  when defined, a wrapping step ends the scroll: the
//                      block returns to LOAD with pos = 0, message retained.

module scroll_message_buffer #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned LW = $clog2(DEPTH + 1),
  localparam int unsigned PW = $clog2(DEPTH + 6)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          tick,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [4:0]    wr_char,
  input  logic          start,
  input  logic          pause,
  input  logic          dir,
  output logic [6:0]    HEX5,
  output logic [6:0]    HEX4,
  output logic [6:0]    HEX3,
  output logic [6:0]    HEX2,
  output logic [6:0]    HEX1,
  output logic [6:0]    HEX0,
  output logic [LW-1:0] len,
  output logic [PW-1:0] pos,
  output logic          full,
  output logic          busy,
  output logic          wrap
);

  // Address width of the store (at least one bit so DEPTH=1 still builds)
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned MEM_N = 1 << AW;
  // Index width wide enough for pos + 5 before the modulo-frame fold
  localparam int unsigned IW    = $clog2(DEPTH + 12);
  localparam logic [6:0]  SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t       state;
  logic [4:0]   msg_mem [MEM_N];

  logic [IW-1:0] frame_len_c;
  logic [IW-1:0] frame_last_c;
  logic [IW-1:0] pos_ext_c;
  logic          wrap_step_c;
  logic [PW-1:0] pos_step_c;
  logic          wr_fire_c;
  logic [IW-1:0] idx_c [6];
  logic [6:0]    seg_c [6];

  // Character code to active-low segment pattern (gfedcba)
  function automatic logic [6:0] glyph(input logic [4:0] code);
    logic [6:0] seg;
    seg = SEG_BLANK;
    if (!code[4]) begin
      case (code[3:0])
        4'h0: seg = 7'h40;
        4'h1: seg = 7'h79;
        4'h2: seg = 7'h24;
        4'h3: seg = 7'h30;
        4'h4: seg = 7'h19;
        4'h5: seg = 7'h12;
        4'h6: seg = 7'h02;
        4'h7: seg = 7'h78;
        4'h8: seg = 7'h00;
        4'h9: seg = 7'h10;
        4'hA: seg = 7'h08;
        4'hB: seg = 7'h03;
        4'hC: seg = 7'h46;
        4'hD: seg = 7'h21;
        4'hE: seg = 7'h06;
        4'hF: seg = 7'h0E;
        default: seg = SEG_BLANK;
      endcase
    end
    return seg;
  endfunction

  // Next window position for one scroll step and whether that step wraps
  always_comb begin
    frame_len_c  = IW'(len) + IW'(6);
    frame_last_c = frame_len_c - IW'(1);
    pos_ext_c    = IW'(pos);
    if (dir) begin
      wrap_step_c = (pos == '0);
      pos_step_c  = wrap_step_c ? PW'(frame_last_c) : pos - PW'(1);
    end else begin
      wrap_step_c = (pos_ext_c == frame_last_c);
      pos_step_c  = wrap_step_c ? '0 : pos + PW'(1);
    end
  end

  // A write lands only when nothing of higher priority claims the cycle
  assign wr_fire_c = wr_en && !clr && !start &&
                     ((state == S_IDLE) || (state == S_LOAD)) &&
                     (len < LW'(DEPTH));

  // Window contents: digit i shows frame element (pos + i) mod F.
  // pos < F and F >= 6, so a single subtraction folds the index.
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      idx_c[i] = pos_ext_c + IW'(i);
      if (idx_c[i] >= frame_len_c) begin
        idx_c[i] = idx_c[i] - frame_len_c;
      end
      seg_c[i] = SEG_BLANK;
      if ((state != S_IDLE) && (idx_c[i] < IW'(len))) begin
        seg_c[i] = glyph(msg_mem[AW'(idx_c[i])]);
      end
    end
  end

  // Message store; contents are don't-care after reset/clear
  always_ff @(posedge clk) begin
    if (wr_fire_c) begin
      msg_mem[AW'(len)] <= wr_char;
    end
  end

  // Control FSM and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      len   <= '0;
      pos   <= '0;
      full  <= 1'b0;
      busy  <= 1'b0;
      wrap  <= 1'b0;
      HEX5  <= SEG_BLANK;
      HEX4  <= SEG_BLANK;
      HEX3  <= SEG_BLANK;
      HEX2  <= SEG_BLANK;
      HEX1  <= SEG_BLANK;
      HEX0  <= SEG_BLANK;
    end else begin
      wrap <= 1'b0;
      HEX5 <= seg_c[0];
      HEX4 <= seg_c[1];
      HEX3 <= seg_c[2];
      HEX2 <= seg_c[3];
      HEX1 <= seg_c[4];
      HEX0 <= seg_c[5];

      if (clr) begin
        state <= S_IDLE;
        len   <= '0;
        pos   <= '0;
        full  <= 1'b0;
        busy  <= 1'b0;
        HEX5  <= SEG_BLANK;
        HEX4  <= SEG_BLANK;
        HEX3  <= SEG_BLANK;
        HEX2  <= SEG_BLANK;
        HEX1  <= SEG_BLANK;
        HEX0  <= SEG_BLANK;
      end else if (start) begin
        // Nothing to scroll from IDLE; otherwise (re)start at frame 0
        if (state != S_IDLE) begin
          state <= S_RUN;
          pos   <= '0;
          busy  <= 1'b1;
        end
      end else begin
        case (state)
          S_IDLE, S_LOAD: begin
            if (wr_fire_c) begin
              len   <= len + LW'(1);
              full  <= (len == LW'(DEPTH - 1));
              state <= S_LOAD;
            end
          end
          S_RUN: begin
            if (pause) begin
              state <= S_HOLD;
            end else if (tick) begin
              wrap <= wrap_step_c;
`ifdef SCROLL_ONESHOT_EN
              if (wrap_step_c) begin
                state <= S_LOAD;
                pos   <= '0;
                busy  <= 1'b0;
              end else begin
                pos <= pos_step_c;
              end
`else
              pos <= pos_step_c;
`endif
            end
          end
          S_HOLD: begin
            if (!pause) begin
              state <= S_RUN;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scroll_message_buffer.sv
// Testbench for scroll_message_buffer (DEPTH = 8).
// Table of per-cycle stimulus records with expected outputs, pushed to a
// scoreboard queue when driven and popped when the DUT result is sampled.
// Hand-written sequences cover reset at power-up and asynchronous reset
// mid-scroll. Expectations adapt when SCROLL_ONESHOT_EN is defined.

module tb_scroll_message_buffer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned LW    = $clog2(DEPTH + 1);
  localparam int unsigned PW    = $clog2(DEPTH + 6);

`ifdef SCROLL_ONESHOT_EN
  localparam bit OS = 1'b1;
`else
  localparam bit OS = 1'b0;
`endif

  localparam logic [6:0] B  = 7'h7F;
  localparam logic [6:0] GD = 7'h21;
  localparam logic [6:0] GE = 7'h06;
  localparam logic [6:0] G1 = 7'h79;
  localparam logic [6:0] N0 = 7'h40;
  localparam logic [6:0] N1 = 7'h79;
  localparam logic [6:0] N2 = 7'h24;
  localparam logic [6:0] N3 = 7'h30;
  localparam logic [6:0] N4 = 7'h19;
  localparam logic [6:0] N5 = 7'h12;

  logic          clk;
  logic          resetn;
  logic          tick;
  logic          clr;
  logic          wr_en;
  logic [4:0]    wr_char;
  logic          start;
  logic          pause;
  logic          dir;
  logic [6:0]    HEX5, HEX4, HEX3, HEX2, HEX1, HEX0;
  logic [LW-1:0] len;
  logic [PW-1:0] pos;
  logic          full;
  logic          busy;
  logic          wrap;

  scroll_message_buffer #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .tick    (tick),
    .clr     (clr),
    .wr_en   (wr_en),
    .wr_char (wr_char),
    .start   (start),
    .pause   (pause),
    .dir     (dir),
    .HEX5    (HEX5),
    .HEX4    (HEX4),
    .HEX3    (HEX3),
    .HEX2    (HEX2),
    .HEX1    (HEX1),
    .HEX0    (HEX0),
    .len     (len),
    .pos     (pos),
    .full    (full),
    .busy    (busy),
    .wrap    (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          tick;
    logic          clr;
    logic          wr_en;
    logic          start;
    logic          pause;
    logic          dir;
    logic [4:0]    ch;
    logic [PW-1:0] pos;
    logic [LW-1:0] len;
    logic          busy;
    logic          full;
    logic          wrap;
    logic [41:0]   hex;   // {HEX5..HEX0}
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic t, input logic c, input logic w,
                              input logic s, input logic p, input logic d,
                              input logic [4:0] ch, input int ps, input int ln,
                              input logic bz, input logic fl, input logic wp,
                              input logic [41:0] hx);
    vec_t v;
    v.tick = t;  v.clr = c;  v.wr_en = w; v.start = s; v.pause = p; v.dir = d;
    v.ch = ch;   v.pos = PW'(ps); v.len = LW'(ln);
    v.busy = bz; v.full = fl; v.wrap = wp; v.hex = hx;
    return v;
  endfunction

  task automatic chk(input string what, input int id, input logic [41:0] act,
                     input logic [41:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", what, id, act, expv);
    end
  endtask

  task automatic drive_idle();
    tick = 1'b0; clr = 1'b0; wr_en = 1'b0; start = 1'b0; wr_char = 5'h00;
  endtask

  // One stimulus cycle, then one quiet cycle so the registered HEX catch up
  task automatic apply(input vec_t v, input int id);
    vec_t e;
    tick = v.tick; clr = v.clr; wr_en = v.wr_en; start = v.start;
    pause = v.pause; dir = v.dir; wr_char = v.ch;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    chk("pos",  id, 42'(pos),  42'(e.pos));
    chk("len",  id, 42'(len),  42'(e.len));
    chk("busy", id, 42'(busy), 42'(e.busy));
    chk("full", id, 42'(full), 42'(e.full));
    chk("wrap", id, 42'(wrap), 42'(e.wrap));
    drive_idle();
    @(negedge clk);
    chk("hex",      id, {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, e.hex);
    chk("wrap_off", id, 42'(wrap), 42'(0));
  endtask

  task automatic chk_reset_vals(input int id);
    chk("rst_hex",  id, {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {B, B, B, B, B, B});
    chk("rst_len",  id, 42'(len),  42'(0));
    chk("rst_pos",  id, 42'(pos),  42'(0));
    chk("rst_busy", id, 42'(busy), 42'(0));
    chk("rst_wrap", id, 42'(wrap), 42'(0));
    chk("rst_full", id, 42'(full), 42'(0));
  endtask

  initial begin
    resetn = 1'b0; pause = 1'b0; dir = 1'b0;
    drive_idle();

    //          tk clr wr st ps dr  ch    pos len bz fl wp  hex
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 5'h0D, 0, 1, 0, 0, 0, {GD, B, B, B, B, B}));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 5'h0E, 0, 2, 0, 0, 0, {GD, GE, B, B, B, B}));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 5'h01, 0, 3, 0, 0, 0, {GD, GE, G1, B, B, B}));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 5'h00, 0, 3, 1, 0, 0, {GD, GE, G1, B, B, B}));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 5'h00, 1, 3, 1, 0, 0, {GE, G1, B, B, B, B}));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 5'h00, 2, 3, 1, 0, 0, {G1, B, B, B, B, B}));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 5'h00, 3, 3, 1, 0, 0, {B, B, B, B, B, B}));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 5'h00, 4, 3, 1, 0, 0, {B, B, B, B, B, GD}));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 5'h00, 5, 3, 1, 0, 0, {B, B, B, B, GD, GE}));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 5'h00, 6, 3, 1, 0, 0, {B, B, B, GD, GE, G1}));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 5'h00, 7, 3, 1, 0, 0, {B, B, GD, GE, G1, B}));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 5'h00, 8, 3, 1, 0, 0, {B, GD, GE, G1, B, B}));
    // Left wrap: 8 -> 0
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 5'h00, 0, 3, !OS, 0, 1, {GD, GE, G1, B, B, B}));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 5'h00, OS ? 0 : 1, 3, !OS, 0, 0,
                      OS ? {GD, GE, G1, B, B, B} : {GE, G1, B, B, B, B}));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 5'h00, 0, 3, 1, 0, 0, {GD, GE, G1, B, B, B}));
    // Right wrap: 0 -> F-1 = 8
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 5'h00, OS ? 0 : 8, 3, !OS, 0, 1,
                      OS ? {GD, GE, G1, B, B, B} : {B, GD, GE, G1, B, B}));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 5'h00, 0, 3, 1, 0, 0, {GD, GE, G1, B, B, B}));
    // Paused: ticks ignored
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 0, 0, 0, 1, 0, 5'h00, 0, 3, 1, 0, 0, {GD, GE, G1, B, B, B}));
    // Release pause together with a tick: still held this cycle
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 5'h00, 0, 3, 1, 0, 0, {GD, GE, G1, B, B, B}));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 5'h00, 1, 3, 1, 0, 0, {GE, G1, B, B, B, B}));
    // Write while running is ignored
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 5'h05, 1, 3, 1, 0, 0, {GE, G1, B, B, B, B}));
    // clr beats tick
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 5'h00, 0, 0, 0, 0, 0, {B, B, B, B, B, B}));
    // start in IDLE is ignored
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 5'h00, 0, 0, 0, 0, 0, {B, B, B, B, B, B}));
    // Fill to DEPTH, then one more write that must be dropped
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 5'h00, 0, 1, 0, 0, 0, {N0, B, B, B, B, B}));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 5'h01, 0, 2, 0, 0, 0, {N0, N1, B, B, B, B}));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 5'h02, 0, 3, 0, 0, 0, {N0, N1, N2, B, B, B}));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 5'h03, 0, 4, 0, 0, 0, {N0, N1, N2, N3, B, B}));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 5'h04, 0, 5, 0, 0, 0, {N0, N1, N2, N3, N4, B}));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 5'h05, 0, 6, 0, 0, 0, {N0, N1, N2, N3, N4, N5}));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 5'h06, 0, 7, 0, 0, 0, {N0, N1, N2, N3, N4, N5}));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 5'h07, 0, 8, 0, 1, 0, {N0, N1, N2, N3, N4, N5}));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 5'h0F, 0, 8, 0, 1, 0, {N0, N1, N2, N3, N4, N5}));
    // Clear, blank-code char, then start+write in one cycle (start wins)
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 5'h00, 0, 0, 0, 0, 0, {B, B, B, B, B, B}));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 5'h10, 0, 1, 0, 0, 0, {B, B, B, B, B, B}));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 5'h03, 0, 1, 1, 0, 0, {B, B, B, B, B, B}));

    // Power-up reset
    repeat (2) @(negedge clk);
    chk_reset_vals(-1);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
    end

    // Asynchronous reset mid-scroll: values must clear without a clock edge
    tick = 1'b1;
    repeat (3) @(negedge clk);
    tick = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    chk_reset_vals(-2);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk_reset_vals(-3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scroll_message_buffer.md
Name: scroll_message_buffer

Overview:
Upstream feeder for the HEX5..HEX0 ticker display. It stores a user-loaded message of up to DEPTH character codes and scrolls a 6-digit window across it. The window advances one position per 1-cycle tick pulse from the ~1 Hz enable generator. It drives active-LOW 7-segment patterns directly and replaces the fixed "dE1" table with a loadable, pausable, bidirectional message.

Parameters:
DEPTH, 8, maximum message length in characters (1..16)
LW, $clog2(DEPTH+1), width of len (derived localparam)
PW, $clog2(DEPTH+6), width of pos (derived localparam)

Ports:
clk  in  1  system clock (CLOCK_50 at top level)
resetn  in  1  asynchronous reset, active-low
tick  in  1  1-cycle scroll enable pulse
clr  in  1  synchronous clear of message and state
wr_en  in  1  write one character at index len
wr_char  in  5  char code: 0x00-0x0F hex glyph 0-9,A,b,C,d,E,F; 0x10-0x1F blank
start  in  1  begin scrolling from pos 0
pause  in  1  level; freezes scrolling while high
dir  in  1  0 = scroll left (pos+1), 1 = scroll right (pos-1)
HEX5..HEX0  out  7 each  active-LOW segments, bit0 = seg a; d=7'b0100001, E=7'b0000110, 1=7'b1111001, blank=7'h7F
len  out  LW  number of stored characters
pos  out  PW  current window start index
full  out  1  len == DEPTH
busy  out  1  state is RUN or HOLD
wrap  out  1  1-cycle pulse when pos wraps

Behaviour:
- Reset (async, resetn=0): state IDLE, len=0, pos=0, wrap=0, all HEX = 7'h7F, message store contents don't-care.
- Frame length F = len + 6: six trailing blanks, so the text fully exits before re-entry. Element k is char[k] for k<len, else blank.
- HEX5 shows element pos, HEX4 pos+1, ... HEX0 pos+5, all indices mod F.
- HEX outputs are registered: they reflect pos/len/state one cycle after those change. In IDLE all HEX are blank.
- States: IDLE, LOAD, RUN, HOLD.
- IDLE/LOAD, wr_en=1, len<DEPTH: char[len]<=wr_char, len<=len+1, state->LOAD.
- wr_en while full: ignored; len and full unchanged.
- wr_en in RUN/HOLD: ignored.
- start in LOAD: pos<=0, state->RUN. start in IDLE: ignored. start in RUN/HOLD: restarts at pos 0.
- start and wr_en in the same cycle: start wins; the write is dropped.
- RUN, tick=1, pause=0:
  - dir=0: pos<=(pos==F-1)?0:pos+1.
  - dir=1: pos<=(pos==0)?F-1:pos-1.
  - wrap<=1 the cycle after a wrapping step, 0 otherwise.
- RUN with pause=1 -> HOLD; HOLD with pause=0 -> RUN. Ticks in HOLD are ignored; the display is frozen.
- start and tick in the same cycle: start wins (pos=0, no step).
- Priority: resetn > clr > start > tick > wr_en.
- clr=1: state->IDLE, len=0, pos=0, wrap=0, display blank next cycle. Applies from any state, including mid-scroll.
- Reset mid-scroll: outputs go to reset values immediately (asynchronous).
- No arithmetic overflow: pos is always < F <= DEPTH+6 and fits in PW bits. len saturates at DEPTH.

Optional Feature:
SCROLL_ONESHOT_EN
- Defined: a wrapping step in RUN also moves the state to LOAD with pos=0. The message is retained and the frame-0 view is shown; further writes may append, and start reruns the scroll.
- Not defined: scrolling repeats continuously until clr, reset or pause.

Test Plan:
- Reset with resetn=0 mid-run -> all HEX=7'h7F, len=0, pos=0, busy=0, wrap=0 immediately.
- Write 0x0D,0x0E,0x01 then start -> after 1 cycle HEX5=0x21, HEX4=0x06, HEX3=0x79, HEX2..HEX0=0x7F, pos=0, busy=1.
- Same message, 6 ticks with dir=0 -> pos=6, HEX5..HEX3=0x7F, HEX2=0x21, HEX1=0x06, HEX0=0x79. 3 more ticks -> pos=0, wrap high exactly 1 cycle. With SCROLL_ONESHOT_EN: busy=0 and further ticks leave pos=0.
- dir=1 from pos=0 with 1 tick -> pos=8 (F-1), wrap pulses, HEX5=0x7F, HEX4=0x21.
- Write 9 chars with DEPTH=8 -> len=8, full=1, 9th char not stored. Write during RUN -> len unchanged.
- pause=1 for 5 ticks -> pos and HEX frozen. clr in the same cycle as tick -> IDLE, len=0, HEX blank next cycle.
